// File: rtl/fir_ctrl_pkg.sv
// rtl/fir_ctrl_pkg.sv - shared sizes and FSM state type for the FIR cmem sequencer
package fir_ctrl_pkg;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam int WIDTH  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/fir_ctrl_dly.sv
// rtl/fir_ctrl_dly.sv - one-stage alignment of MAC strobes to the cmem read latency
module fir_ctrl_dly (
  input  logic       clk2,
  input  logic       rstn,
  input  logic [2:0] strb_i,
  output logic [2:0] strb_o
);

  logic [2:0] strb_q;

  always_ff @(posedge clk2 or negedge rstn) begin
    if (!rstn) begin
      strb_q <= 3'b000;
    end else begin
      strb_q <= strb_i;
    end
  end

  assign strb_o = strb_q;

endmodule

// File: rtl/fir_cmem_ctrl.sv
// rtl/fir_cmem_ctrl.sv - cmem port arbiter and tap-walk sequencer, one FIR output per sample
module fir_cmem_ctrl
  import fir_ctrl_pkg::*;
(
  input  logic              clk2,
  input  logic              rstn,
  input  logic              h_req,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [WIDTH-1:0]  h_data,
  output logic              h_gnt,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [ADDR_W-1:0] taps_m1,
  output logic              cload,
  output logic [ADDR_W-1:0] caddr,
  output logic [WIDTH-1:0]  cin,
  output logic              ren,
  output logic [ADDR_W-1:0] raddr,
  output logic              dwe,
  output logic [ADDR_W-1:0] dptr,
  output logic [ADDR_W-1:0] draddr,
  output logic              mac_en,
  output logic              mac_clr,
  output logic              mac_last,
  output logic              y_valid,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] dptr_q, dptr_d;
  logic [ADDR_W-1:0] n1_q, n1_d;
  logic              cload_q, cload_d;
  logic [ADDR_W-1:0] caddr_q, caddr_d;
  logic [WIDTH-1:0]  cin_q, cin_d;
  logic              ren_q, ren_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [ADDR_W-1:0] draddr_q, draddr_d;
  logic              y_valid_q, y_valid_d;
  logic [2:0]        strb_in, strb_out;
  logic              accept;

  // Samples win over the host; host writes only land while idle, so reads and writes never overlap.
  assign s_ready = (state_q == IDLE);
  assign busy    = !s_ready;
  assign accept  = s_valid && s_ready;
  assign h_gnt   = s_ready && h_req && !s_valid;
  assign dwe     = accept;

  always_comb begin
    state_d   = state_q;
    dptr_d    = dptr_q;
    n1_d      = n1_q;
    ren_d     = ren_q;
    raddr_d   = raddr_q;
    draddr_d  = draddr_q;
    y_valid_d = 1'b0;
    cload_d   = h_gnt;
    caddr_d   = h_gnt ? h_addr : caddr_q;
    cin_d     = h_gnt ? h_data : cin_q;
    case (state_q)
      IDLE: begin
        if (s_valid) begin
          state_d  = RUN;
          dptr_d   = dptr_q + 1'b1;
          n1_d     = taps_m1;
          ren_d    = 1'b1;
          raddr_d  = '0;
          draddr_d = dptr_q;
        end
      end
      RUN: begin
        // raddr_q doubles as the tap index k; draddr walks backwards from the newest sample.
        if (raddr_q == n1_q) begin
          state_d = DRAIN;
          ren_d   = 1'b0;
        end else begin
          raddr_d  = raddr_q + 1'b1;
          draddr_d = draddr_q - 1'b1;
        end
      end
      DRAIN: begin
        state_d   = DONE;
        y_valid_d = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk2 or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      dptr_q    <= '0;
      n1_q      <= '0;
      cload_q   <= 1'b0;
      caddr_q   <= '0;
      cin_q     <= '0;
      ren_q     <= 1'b0;
      raddr_q   <= '0;
      draddr_q  <= '0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dptr_q    <= dptr_d;
      n1_q      <= n1_d;
      cload_q   <= cload_d;
      caddr_q   <= caddr_d;
      cin_q     <= cin_d;
      ren_q     <= ren_d;
      raddr_q   <= raddr_d;
      draddr_q  <= draddr_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign strb_in = {ren_q, ren_q && (raddr_q == '0), ren_q && (raddr_q == n1_q)};

  fir_ctrl_dly u_dly (
    .clk2   (clk2),
    .rstn   (rstn),
    .strb_i (strb_in),
    .strb_o (strb_out)
  );

  assign {mac_en, mac_clr, mac_last} = strb_out;

  assign cload   = cload_q;
  assign caddr   = caddr_q;
  assign cin     = cin_q;
  assign ren     = ren_q;
  assign raddr   = raddr_q;
  assign dptr    = dptr_q;
  assign draddr  = draddr_q;
  assign y_valid = y_valid_q;

endmodule
